// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_pkg
//  Purpose  : Shared state encoding, wait-timer width and opcode classes for
//             the multi-cycle RV32I controller and decoder.
//  Revision : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

   localparam int WAIT_W = 8;

   // HALT and FAULT share encoding 7; a separate flag tells them apart.
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM_RD = 3'd4,
      S_MEM_WR = 3'd5,
      S_WB     = 3'd6,
      S_STOP   = 3'd7
   } state_t;

   typedef enum logic [6:0] {
      OPC_LOAD   = 7'b0000011,
      OPC_OPIMM  = 7'b0010011,
      OPC_AUIPC  = 7'b0010111,
      OPC_STORE  = 7'b0100011,
      OPC_OP     = 7'b0110011,
      OPC_LUI    = 7'b0110111,
      OPC_BRANCH = 7'b1100011,
      OPC_JALR   = 7'b1100111,
      OPC_JAL    = 7'b1101111,
      OPC_SYSTEM = 7'b1110011
   } opclass_t;

   function automatic logic is_wait_state(input state_t s);
      return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
   endfunction

endpackage
`default_nettype wire

// File: rtl/wait_timer.sv
`default_nettype none
// ============================================================================
//  Module   : wait_timer
//  Purpose  : Counts un-ready memory cycles; flags the cycle whose increment
//             reaches the limit.
//  Revision : 1.0 - initial release
// ============================================================================
module wait_timer
   import ctrl_pkg::*;
(
   input  logic              sysclk,
   input  logic              reset,
   input  logic              clear,
   input  logic              enable,
   input  logic [WAIT_W-1:0] limit,
   output logic [WAIT_W-1:0] count,
   output logic              expired
);

   logic [WAIT_W-1:0] r_count;
   logic [WAIT_W-1:0] w_count_inc;

   assign w_count_inc = r_count + WAIT_W'(1);

   always_ff @(posedge sysclk) begin
      if (reset || clear) begin
         r_count <= '0;
      end else if (enable) begin
         r_count <= w_count_inc;
      end
   end

   assign count   = r_count;
   assign expired = enable && (w_count_inc >= limit);

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_ctrl
//  Purpose  : Multi-cycle RV32I sequencing FSM with ready handshakes, timeout
//             fault and halt. Optional perf counters: MULTICYCLE_CTRL_PERF_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
   import ctrl_pkg::*;
#(
   parameter int unsigned  WAIT_MAX = 16,
   parameter logic [31:0]  RESET_PC = 32'h0000_0000
)(
   input  logic        sysclk,
   input  logic        reset,
   input  logic        run,
   input  logic        is_load,
   input  logic        is_store,
   input  logic        is_halt,
   input  logic        dec_reg_we,
   input  logic        imem_ready,
   input  logic        dmem_ready,
   output logic        imem_re,
   output logic        ir_we,
   output logic        alu_we,
   output logic        dmem_re,
   output logic        dmem_we,
   output logic        rf_we,
   output logic        pc_we,
   output logic [31:0] pc_init,
   output logic        retire,
   output logic        halted,
   output logic        fault,
   output logic [2:0]  state
`ifdef MULTICYCLE_CTRL_PERF_EN
   ,
   output logic [31:0] cycle_cnt,
   output logic [31:0] instret_cnt
`endif
);

   localparam logic [WAIT_W-1:0] c_wait_limit = WAIT_W'(WAIT_MAX);

   state_t            r_state;
   state_t            w_state_next;
   logic              r_fault;
   logic              w_enter_fault;
   logic              w_ready;
   logic              w_wait_en;
   logic              w_wait_expired;
   logic [WAIT_W-1:0] w_unused_wait_count;

   logic w_imem_re, w_ir_we, w_alu_we, w_dmem_re, w_dmem_we;
   logic w_rf_we, w_pc_we, w_retire;

   assign w_ready   = (r_state == S_FETCH) ? imem_ready : dmem_ready;
   assign w_wait_en = is_wait_state(r_state) && !w_ready;

   wait_timer u_wait_timer (
      .sysclk  (sysclk),
      .reset   (reset),
      .clear   (w_state_next != r_state),
      .enable  (w_wait_en),
      .limit   (c_wait_limit),
      .count   (w_unused_wait_count),
      .expired (w_wait_expired)
   );

   always_ff @(posedge sysclk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_fault <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if (r_state != S_STOP) begin
            r_fault <= w_enter_fault;
         end
      end
   end

   always_comb begin
      w_state_next  = r_state;
      w_enter_fault = 1'b0;
      w_imem_re     = 1'b0;
      w_ir_we       = 1'b0;
      w_alu_we      = 1'b0;
      w_dmem_re     = 1'b0;
      w_dmem_we     = 1'b0;
      w_rf_we       = 1'b0;
      w_pc_we       = 1'b0;
      w_retire      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (run) w_state_next = S_FETCH;
         end
         S_FETCH: begin
            w_imem_re = 1'b1;
            if (imem_ready) begin
               w_ir_we      = 1'b1;
               w_state_next = S_DECODE;
            end else if (w_wait_expired) begin
               w_state_next  = S_STOP;
               w_enter_fault = 1'b1;
            end
         end
         S_DECODE: begin
            if (is_halt) begin
               w_state_next = S_STOP;
            end else if (is_load && is_store) begin
               w_state_next  = S_STOP;
               w_enter_fault = 1'b1;
            end else begin
               w_state_next = S_EXEC;
            end
         end
         S_EXEC: begin
            w_alu_we = 1'b1;
            if (is_load)       w_state_next = S_MEM_RD;
            else if (is_store) w_state_next = S_MEM_WR;
            else               w_state_next = S_WB;
         end
         S_MEM_RD: begin
            w_dmem_re = 1'b1;
            if (dmem_ready) begin
               w_state_next = S_WB;
            end else if (w_wait_expired) begin
               w_state_next  = S_STOP;
               w_enter_fault = 1'b1;
            end
         end
         S_MEM_WR: begin
            w_dmem_we = 1'b1;
            if (dmem_ready) begin
               w_pc_we      = 1'b1;
               w_retire     = 1'b1;
               w_state_next = run ? S_FETCH : S_IDLE;
            end else if (w_wait_expired) begin
               w_state_next  = S_STOP;
               w_enter_fault = 1'b1;
            end
         end
         S_WB: begin
            w_rf_we      = dec_reg_we;
            w_pc_we      = 1'b1;
            w_retire     = 1'b1;
            w_state_next = run ? S_FETCH : S_IDLE;
         end
         S_STOP: begin
            w_state_next = S_STOP;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Outputs are forced quiet while reset is held, even mid-instruction.
   assign imem_re = w_imem_re & ~reset;
   assign ir_we   = w_ir_we   & ~reset;
   assign alu_we  = w_alu_we  & ~reset;
   assign dmem_re = w_dmem_re & ~reset;
   assign dmem_we = w_dmem_we & ~reset;
   assign rf_we   = w_rf_we   & ~reset;
   assign pc_we   = w_pc_we   & ~reset;
   assign retire  = w_retire  & ~reset;
   assign halted  = (r_state == S_STOP) && !r_fault && !reset;
   assign fault   = (r_state == S_STOP) &&  r_fault && !reset;
   assign state   = reset ? 3'd0 : r_state;
   assign pc_init = RESET_PC;

`ifdef MULTICYCLE_CTRL_PERF_EN
   logic [31:0] r_cycle_cnt;
   logic [31:0] r_instret_cnt;

   always_ff @(posedge sysclk) begin
      if (reset) begin
         r_cycle_cnt   <= '0;
         r_instret_cnt <= '0;
      end else begin
         if ((r_state != S_IDLE) && (r_state != S_STOP)) begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
         end
         if (w_retire) begin
            r_instret_cnt <= r_instret_cnt + 32'd1;
         end
      end
   end

   assign cycle_cnt   = r_cycle_cnt;
   assign instret_cnt = r_instret_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_ctrl
//  Purpose  : Self-checking bench for multicycle_ctrl (cycle-by-cycle vectors).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

   // Input packing: {reset, run, is_load, is_store, is_halt, dec_reg_we, imem_ready, dmem_ready}
   // Output packing: {imem_re, ir_we, alu_we, dmem_re, dmem_we, rf_we, pc_we, retire, halted, fault}
   typedef struct {
      logic [7:0] in;
      logic [2:0] st;
      logic [9:0] out;
   } vec_t;

   localparam logic [31:0] c_reset_pc = 32'h0000_0000;

   localparam logic [9:0] O_NONE   = 10'b0000000000;
   localparam logic [9:0] O_F_HIT  = 10'b1100000000;
   localparam logic [9:0] O_F_WAIT = 10'b1000000000;
   localparam logic [9:0] O_EXEC   = 10'b0010000000;
   localparam logic [9:0] O_MRD    = 10'b0001000000;
   localparam logic [9:0] O_MWR    = 10'b0000100000;
   localparam logic [9:0] O_MWR_OK = 10'b0000101100;
   localparam logic [9:0] O_WB_RF  = 10'b0000011100;
   localparam logic [9:0] O_WB     = 10'b0000001100;
   localparam logic [9:0] O_HALT   = 10'b0000000010;
   localparam logic [9:0] O_FAULT  = 10'b0000000001;

   localparam logic [7:0] I_RST    = 8'b1000_0000;
   localparam logic [7:0] I_IDLE   = 8'b0000_0000;
   localparam logic [7:0] I_RUN    = 8'b0100_0000;
   localparam logic [7:0] I_ALU_RF = 8'b0100_0110;
   localparam logic [7:0] I_ALU    = 8'b0100_0010;
   localparam logic [7:0] I_ALU_N  = 8'b0000_0110;
   localparam logic [7:0] I_ALU_IW = 8'b0100_0100;
   localparam logic [7:0] I_LD     = 8'b0110_0110;
   localparam logic [7:0] I_LD_RDY = 8'b0110_0111;
   localparam logic [7:0] I_ST     = 8'b0101_0110;
   localparam logic [7:0] I_ST_RDY = 8'b0101_0111;
   localparam logic [7:0] I_ST_END = 8'b0001_0111;
   localparam logic [7:0] I_HALT_P = 8'b0111_1110;
   localparam logic [7:0] I_HALT   = 8'b0100_1010;
   localparam logic [7:0] I_LDST   = 8'b0111_0110;

   logic        sysclk;
   logic        reset, run, is_load, is_store, is_halt, dec_reg_we, imem_ready, dmem_ready;
   logic        imem_re, ir_we, alu_we, dmem_re, dmem_we, rf_we, pc_we, retire, halted, fault;
   logic [31:0] pc_init;
   logic [2:0]  state;
`ifdef MULTICYCLE_CTRL_PERF_EN
   logic [31:0] cycle_cnt, instret_cnt;
`endif

   int   n_cmp = 0;
   int   n_err = 0;
   vec_t tbl[$];
   vec_t exp_q[$];

   multicycle_ctrl #(.WAIT_MAX(16), .RESET_PC(c_reset_pc)) dut (
      .sysclk      (sysclk),
      .reset       (reset),
      .run         (run),
      .is_load     (is_load),
      .is_store    (is_store),
      .is_halt     (is_halt),
      .dec_reg_we  (dec_reg_we),
      .imem_ready  (imem_ready),
      .dmem_ready  (dmem_ready),
      .imem_re     (imem_re),
      .ir_we       (ir_we),
      .alu_we      (alu_we),
      .dmem_re     (dmem_re),
      .dmem_we     (dmem_we),
      .rf_we       (rf_we),
      .pc_we       (pc_we),
      .pc_init     (pc_init),
      .retire      (retire),
      .halted      (halted),
      .fault       (fault),
      .state       (state)
`ifdef MULTICYCLE_CTRL_PERF_EN
      ,
      .cycle_cnt   (cycle_cnt),
      .instret_cnt (instret_cnt)
`endif
   );

   initial sysclk = 1'b0;
   always #5 sysclk = ~sysclk;

   function automatic vec_t mk(input logic [7:0] i, input logic [2:0] s, input logic [9:0] o);
      vec_t v;
      v.in  = i;
      v.st  = s;
      v.out = o;
      return v;
   endfunction

   task automatic check_out();
      vec_t        e;
      logic [12:0] got;
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL scoreboard: empty queue when output sampled at %0t", $time);
         return;
      end
      e   = exp_q.pop_front();
      got = {state, imem_re, ir_we, alu_we, dmem_re, dmem_we, rf_we, pc_we, retire, halted, fault};
      n_cmp++;
      if (got !== {e.st, e.out}) begin
         n_err++;
         $display("FAIL outputs @%0t in=%b: got st=%0d o=%b, want st=%0d o=%b",
                  $time, e.in, got[12:10], got[9:0], e.st, e.out);
      end
      if (e.st == 3'd0) begin
         n_cmp++;
         if (pc_init !== c_reset_pc) begin
            n_err++;
            $display("FAIL pc_init @%0t: got %h want %h", $time, pc_init, c_reset_pc);
         end
      end
   endtask

   // Drive at the falling edge, check 1 time unit later, then move to the next falling edge.
   task automatic apply(input vec_t v);
      {reset, run, is_load, is_store, is_halt, dec_reg_we, imem_ready, dmem_ready} = v.in;
      exp_q.push_back(v);
      #1;
      check_out();
      @(negedge sysclk);
   endtask

   task automatic cyc(input logic [7:0] i, input logic [2:0] s, input logic [9:0] o);
      apply(mk(i, s, o));
   endtask

   task automatic check_perf(input logic [31:0] want_cyc, input logic [31:0] want_ret, input string tag);
`ifdef MULTICYCLE_CTRL_PERF_EN
      n_cmp++;
      if (cycle_cnt !== want_cyc || instret_cnt !== want_ret) begin
         n_err++;
         $display("FAIL perf_%s: got cycle=%0d instret=%0d, want cycle=%0d instret=%0d",
                  tag, cycle_cnt, instret_cnt, want_cyc, want_ret);
      end
`else
      if (want_cyc == 32'hFFFF_FFFF && want_ret == 32'hFFFF_FFFF) $display("perf %s n/a", tag);
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      {reset, run, is_load, is_store, is_halt, dec_reg_we, imem_ready, dmem_ready} = I_RST;
      @(negedge sysclk);

      // reset, idle hold, ALU ops, load with waits, store, run drop mid-instruction
      repeat (2) tbl.push_back(mk(I_RST, 3'd0, O_NONE));
      repeat (5) tbl.push_back(mk(I_IDLE, 3'd0, O_NONE));
      tbl.push_back(mk(I_ALU_RF, 3'd0, O_NONE));
      tbl.push_back(mk(I_ALU_RF, 3'd1, O_F_HIT));
      tbl.push_back(mk(I_ALU_RF, 3'd2, O_NONE));
      tbl.push_back(mk(I_ALU_RF, 3'd3, O_EXEC));
      tbl.push_back(mk(I_ALU_RF, 3'd6, O_WB_RF));
      tbl.push_back(mk(I_ALU,    3'd1, O_F_HIT));
      tbl.push_back(mk(I_ALU,    3'd2, O_NONE));
      tbl.push_back(mk(I_ALU,    3'd3, O_EXEC));
      tbl.push_back(mk(I_ALU,    3'd6, O_WB));
      tbl.push_back(mk(I_LD,     3'd1, O_F_HIT));
      tbl.push_back(mk(I_LD,     3'd2, O_NONE));
      tbl.push_back(mk(I_LD,     3'd3, O_EXEC));
      repeat (3) tbl.push_back(mk(I_LD, 3'd4, O_MRD));
      tbl.push_back(mk(I_LD_RDY, 3'd4, O_MRD));
      tbl.push_back(mk(I_LD_RDY, 3'd6, O_WB_RF));
      tbl.push_back(mk(I_ST_RDY, 3'd1, O_F_HIT));
      tbl.push_back(mk(I_ST_RDY, 3'd2, O_NONE));
      tbl.push_back(mk(I_ST_RDY, 3'd3, O_EXEC));
      tbl.push_back(mk(I_ST_END, 3'd5, O_MWR_OK));
      tbl.push_back(mk(I_IDLE,   3'd0, O_NONE));
      tbl.push_back(mk(I_ALU_RF, 3'd0, O_NONE));
      tbl.push_back(mk(I_ALU_N,  3'd1, O_F_HIT));
      tbl.push_back(mk(I_ALU_N,  3'd2, O_NONE));
      tbl.push_back(mk(I_ALU_N,  3'd3, O_EXEC));
      tbl.push_back(mk(I_ALU_N,  3'd6, O_WB_RF));
      tbl.push_back(mk(I_ALU_N,  3'd0, O_NONE));
      tbl.push_back(mk(I_ST,     3'd0, O_NONE));
      tbl.push_back(mk(I_ST,     3'd1, O_F_HIT));
      tbl.push_back(mk(I_ST,     3'd2, O_NONE));
      tbl.push_back(mk(I_ST,     3'd3, O_EXEC));
      repeat (2) tbl.push_back(mk(I_ST, 3'd5, O_MWR));
      tbl.push_back(mk(I_ST_RDY, 3'd5, O_MWR_OK));
      tbl.push_back(mk(I_ALU_IW, 3'd1, O_F_WAIT));
      tbl.push_back(mk(I_ALU_RF, 3'd1, O_F_HIT));
      tbl.push_back(mk(I_ALU_RF, 3'd2, O_NONE));
      tbl.push_back(mk(I_ALU_RF, 3'd3, O_EXEC));
      tbl.push_back(mk(I_ALU_N,  3'd6, O_WB_RF));
      tbl.push_back(mk(I_IDLE,   3'd0, O_NONE));

      for (int k = 0; k < tbl.size(); k++) apply(tbl[k]);

      // fetch never ready: 16 wait cycles then terminal fault, run ignored
      cyc(I_RST, 3'd0, O_NONE);
      cyc(I_RUN, 3'd0, O_NONE);
      repeat (16) cyc(I_RUN, 3'd1, O_F_WAIT);
      cyc(I_RUN,           3'd7, O_FAULT);
      cyc(I_IDLE,          3'd7, O_FAULT);
      cyc(8'b0100_0011,    3'd7, O_FAULT);

      // ready exactly on the limit cycle wins; timer restarts per state
      cyc(I_RST, 3'd0, O_NONE);
      cyc(I_RUN, 3'd0, O_NONE);
      repeat (15) cyc(I_RUN, 3'd1, O_F_WAIT);
      cyc(I_LD, 3'd1, O_F_HIT);
      cyc(I_LD, 3'd2, O_NONE);
      cyc(I_LD, 3'd3, O_EXEC);
      repeat (15) cyc(I_LD, 3'd4, O_MRD);
      cyc(I_LD_RDY, 3'd4, O_MRD);
      cyc(I_LD_RDY, 3'd6, O_WB_RF);
      cyc(I_LD, 3'd1, O_F_HIT);
      cyc(I_LD, 3'd2, O_NONE);
      cyc(I_LD, 3'd3, O_EXEC);
      repeat (16) cyc(I_LD, 3'd4, O_MRD);
      cyc(I_LD, 3'd7, O_FAULT);

      // halt has priority over the load+store fault; terminal, no retire
      cyc(I_RST, 3'd0, O_NONE);
      cyc(I_RUN, 3'd0, O_NONE);
      cyc(I_HALT_P, 3'd1, O_F_HIT);
      cyc(I_HALT_P, 3'd2, O_NONE);
      cyc(I_HALT_P, 3'd7, O_HALT);
      cyc(I_IDLE,   3'd7, O_HALT);
      cyc(I_HALT_P, 3'd7, O_HALT);

      // load and store together faults
      cyc(I_RST, 3'd0, O_NONE);
      cyc(I_RUN, 3'd0, O_NONE);
      cyc(I_LDST, 3'd1, O_F_HIT);
      cyc(I_LDST, 3'd2, O_NONE);
      cyc(I_LDST, 3'd7, O_FAULT);
      cyc(I_LDST, 3'd7, O_FAULT);

      // reset in MEM_RD with ready pending
      cyc(I_RST, 3'd0, O_NONE);
      cyc(I_RUN, 3'd0, O_NONE);
      cyc(I_LD, 3'd1, O_F_HIT);
      cyc(I_LD, 3'd2, O_NONE);
      cyc(I_LD, 3'd3, O_EXEC);
      cyc(I_LD, 3'd4, O_MRD);
      cyc(8'b1110_0111, 3'd0, O_NONE);
      cyc(I_IDLE, 3'd0, O_NONE);
      cyc(I_IDLE, 3'd0, O_NONE);

      // three ALU ops then halt: 14 active cycles, 3 retirements
      cyc(I_RST, 3'd0, O_NONE);
      check_perf(32'd0, 32'd0, "reset");
      cyc(I_ALU_RF, 3'd0, O_NONE);
      repeat (3) begin
         cyc(I_ALU_RF, 3'd1, O_F_HIT);
         cyc(I_ALU_RF, 3'd2, O_NONE);
         cyc(I_ALU_RF, 3'd3, O_EXEC);
         cyc(I_ALU_RF, 3'd6, O_WB_RF);
      end
      cyc(I_HALT, 3'd1, O_F_HIT);
      cyc(I_HALT, 3'd2, O_NONE);
      cyc(I_HALT, 3'd7, O_HALT);
      check_perf(32'd14, 32'd3, "halt");
      repeat (4) cyc(I_HALT, 3'd7, O_HALT);
      check_perf(32'd14, 32'd3, "frozen");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
